// File: rtl/trans_pkg.sv
// Shared transaction layout, frame sizing and serializer state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional feature: TRANS_SER_CSUM_EN adds the CSUM serializer state.
package trans_pkg;

    localparam int TRANS_W     = 128;
    localparam int TRANS_BYTES = TRANS_W / 8;

    localparam int SENDER_MSB      = 127;
    localparam int SENDER_LSB      = 80;
    localparam int RECEIVER_MSB    = 79;
    localparam int RECEIVER_LSB    = 32;
    localparam int AMOUNT_MSB      = 31;
    localparam int AMOUNT_LSB      = 10;
    localparam int BIT_BLOCK_START = 9;

    typedef struct packed {
        logic [SENDER_MSB-SENDER_LSB:0]     sender_id;
        logic [RECEIVER_MSB-RECEIVER_LSB:0] receiver_id;
        logic [AMOUNT_MSB-AMOUNT_LSB:0]     amount;
        logic                               block_start;
        logic [BIT_BLOCK_START-1:0]         reserved;
    } trans_t;

`ifdef TRANS_SER_CSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_CSUM
    } ser_state_e;
`else
    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } ser_state_e;
`endif

endpackage

// File: rtl/trans_fifo.sv
// Generic synchronous FIFO with show-ahead head, level, full and empty.
// Latency: a pushed word is visible at pop_dat_o the cycle after the push.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
// Ports: push_i/push_dat_i write side, pop_i/pop_dat_o read side (head word),
//        full_o/empty_o/level_o occupancy (level counts 0..DEPTH inclusive).
module trans_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               push_dat_i,
    input  logic                       pop_i,
    output logic [W-1:0]               pop_dat_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q,  level_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o    = (level_q == (AW+1)'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign pop_dat_o = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a full FIFO still takes a push.
    always_comb begin
        pop_ok   = pop_i && !empty_o;
        push_ok  = push_i && (!full_o || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            level_d = level_q + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/trans_serializer.sv
// Buffers 128-bit transactions and emits each as an MSB-first byte frame.
// Latency: valid_i at cycle N -> first byte at N+2; one bubble cycle between frames.
// Backpressure: tx outputs hold while stalled; input has none, so overflow drops and counts.
// Ports: data_i/valid_i transaction input; tx_data_o/tx_valid_o/tx_ready_i/tx_last_o
//        byte stream; fifo_level_o, drop_cnt_o (saturating), busy_o status.
// Optional feature: define TRANS_SER_CSUM_EN to append an XOR checksum byte (17-byte frames).
module trans_serializer
    import trans_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [TRANS_W-1:0]            data_i,
    input  logic                          valid_i,
    output logic [7:0]                    tx_data_o,
    output logic                          tx_valid_o,
    input  logic                          tx_ready_i,
    output logic                          tx_last_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic [DROP_CNT_W-1:0]         drop_cnt_o,
    output logic                          busy_o
);

    localparam int                IDX_W    = $clog2(TRANS_BYTES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(TRANS_BYTES - 1);

    ser_state_e               state_q, state_d;
    logic [TRANS_W-1:0]       shift_q, shift_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [7:0]               tx_dat_q, tx_dat_d;
    logic                     tx_vld_q, tx_vld_d;
    logic                     tx_last_q, tx_last_d;
    logic [DROP_CNT_W-1:0]    drop_q, drop_d;
`ifdef TRANS_SER_CSUM_EN
    logic [7:0]               csum_q, csum_d;
`endif

    trans_t                   in_trans;
    logic [TRANS_W-1:0]       fifo_head;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     tx_hs;

    assign in_trans = data_i;

    trans_fifo #(
        .W     (TRANS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (valid_i),
        .push_dat_i (in_trans),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level_o)
    );

    assign tx_hs      = tx_vld_q && tx_ready_i;
    assign tx_data_o  = tx_dat_q;
    assign tx_valid_o = tx_vld_q;
    assign tx_last_o  = tx_last_q;
    assign drop_cnt_o = drop_q;
    assign busy_o     = !fifo_empty || (state_q != ST_IDLE);

    // Output byte/valid/last are computed one cycle ahead so they come
    // straight from flops and stay frozen whenever no handshake occurs.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        tx_dat_d  = tx_dat_q;
        tx_vld_d  = tx_vld_q;
        tx_last_d = tx_last_q;
        fifo_pop  = 1'b0;
`ifdef TRANS_SER_CSUM_EN
        csum_d    = csum_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_head;
                    idx_d     = '0;
                    tx_dat_d  = fifo_head[TRANS_W-1 -: 8];
                    tx_vld_d  = 1'b1;
                    tx_last_d = 1'b0;
                    state_d   = ST_SEND;
`ifdef TRANS_SER_CSUM_EN
                    csum_d    = '0;
`endif
                end
            end
            ST_SEND: begin
                if (tx_hs) begin
                    shift_d = {shift_q[TRANS_W-9:0], 8'h00};
                    idx_d   = idx_q + IDX_W'(1);
`ifdef TRANS_SER_CSUM_EN
                    csum_d  = csum_q ^ shift_q[TRANS_W-1 -: 8];
`endif
                    if (idx_q == LAST_IDX) begin
`ifdef TRANS_SER_CSUM_EN
                        tx_dat_d  = csum_d;
                        tx_vld_d  = 1'b1;
                        tx_last_d = 1'b1;
                        state_d   = ST_CSUM;
`else
                        tx_dat_d  = '0;
                        tx_vld_d  = 1'b0;
                        tx_last_d = 1'b0;
                        state_d   = ST_IDLE;
`endif
                    end else begin
                        tx_dat_d  = shift_q[TRANS_W-9 -: 8];
`ifdef TRANS_SER_CSUM_EN
                        tx_last_d = 1'b0;
`else
                        tx_last_d = (idx_q == LAST_IDX - IDX_W'(1));
`endif
                    end
                end
            end
`ifdef TRANS_SER_CSUM_EN
            ST_CSUM: begin
                if (tx_hs) begin
                    tx_dat_d  = '0;
                    tx_vld_d  = 1'b0;
                    tx_last_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Drop only when the word truly has nowhere to go this cycle.
    always_comb begin
        drop_d = drop_q;
        if (valid_i && fifo_full && !fifo_pop && (drop_q != '1)) begin
            drop_d = drop_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            idx_q     <= '0;
            tx_dat_q  <= '0;
            tx_vld_q  <= 1'b0;
            tx_last_q <= 1'b0;
            drop_q    <= '0;
`ifdef TRANS_SER_CSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            tx_dat_q  <= tx_dat_d;
            tx_vld_q  <= tx_vld_d;
            tx_last_q <= tx_last_d;
            drop_q    <= drop_d;
`ifdef TRANS_SER_CSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_trans_serializer.sv
// Directed bench for trans_serializer: latency, backpressure, overflow,
// back-to-back framing, mid-frame reset; checksum byte when TRANS_SER_CSUM_EN.
// Stimulus driven 1ns after the rising edge; outputs sampled at the same point.
`timescale 1ns/1ps
module tb_trans_serializer;

    localparam int FIFO_DEPTH = 4;
    localparam int DROP_CNT_W = 16;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
`ifdef TRANS_SER_CSUM_EN
    localparam int NB = 17;
`else
    localparam int NB = 16;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [127:0]           data_i;
    logic                   valid_i;
    logic [7:0]             tx_data_o;
    logic                   tx_valid_o;
    logic                   tx_ready_i;
    logic                   tx_last_o;
    logic [LVL_W-1:0]       fifo_level_o;
    logic [DROP_CNT_W-1:0]  drop_cnt_o;
    logic                   busy_o;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    trans_serializer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DROP_CNT_W (DROP_CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .tx_data_o    (tx_data_o),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready_i),
        .tx_last_o    (tx_last_o),
        .fifo_level_o (fifo_level_o),
        .drop_cnt_o   (drop_cnt_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame byte i of word w; index 16 is the XOR checksum.
    function automatic logic [7:0] exp_byte(input logic [127:0] w, input int i);
        logic [7:0] x;
        x = '0;
        if (i < 16) begin
            x = w[127-8*i -: 8];
        end else begin
            for (int k = 0; k < 16; k++) x = x ^ w[127-8*k -: 8];
        end
        return x;
    endfunction

    // Byte i of word j is {j, i}: each byte identifies frame and position.
    function automatic logic [127:0] mk_word(input int j);
        logic [127:0] w;
        logic [3:0]   jn;
        logic [3:0]   in;
        w  = '0;
        jn = j[3:0];
        for (int i = 0; i < 16; i++) begin
            in = i[3:0];
            w[127-8*i -: 8] = {jn, in};
        end
        return w;
    endfunction

    task automatic push(input logic [127:0] w);
        data_i  = w;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        data_i  = '0;
    endtask

    // Receives one frame with ready held high; reports the cycle of the first
    // byte and of the last-byte handshake.
    task automatic rx_frame(input logic [127:0] w, input string tag,
                            output int start_c, output int last_c);
        int guard;
        guard      = 0;
        tx_ready_i = 1'b1;
        while (tx_valid_o !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        chk({tag, " start"}, tx_valid_o, 1'b1);
        start_c = cyc;
        last_c  = cyc;
        for (int i = 0; i < NB; i++) begin
            chk($sformatf("%s b%0d valid", tag, i), tx_valid_o, 1'b1);
            chk($sformatf("%s b%0d data", tag, i), tx_data_o, exp_byte(w, i));
            chk($sformatf("%s b%0d last", tag, i), tx_last_o, (i == NB-1));
            if (i == NB-1) last_c = cyc;
            tick();
        end
    endtask

    initial begin
        logic [127:0] w1;
        logic [127:0] wbp;
        logic [127:0] w6;
        int pc, s0, l0, s1, l1, s2, l2, k, c, guard;

        rst_n      = 1'b0;
        data_i     = '0;
        valid_i    = 1'b0;
        tx_ready_i = 1'b0;
        tick();
        tick();
        chk("rst valid", tx_valid_o, 1'b0);
        chk("rst data", tx_data_o, 8'h00);
        chk("rst last", tx_last_o, 1'b0);
        chk("rst level", fifo_level_o, 0);
        chk("rst drop", drop_cnt_o, 0);
        chk("rst busy", busy_o, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single word, ready high: first byte exactly two cycles after valid_i.
        w1 = 128'h0123456789AB_CDEF01234567_00000E_00;
        tx_ready_i = 1'b1;
        pc = cyc;
        push(w1);
        chk("t1 level after push", fifo_level_o, 1);
        chk("t1 no early valid", tx_valid_o, 1'b0);
        chk("t1 busy", busy_o, 1'b1);
        rx_frame(w1, "t1", s0, l0);
        chk("t1 latency", s0 - pc, 2);
        chk("t1 frame len", l0 - s0, NB - 1);
        chk("t1 idle valid", tx_valid_o, 1'b0);
        chk("t1 idle busy", busy_o, 1'b0);

        // Backpressure: ready pattern 1,0,0,1 repeating.
        wbp = 128'h00112233445566778899AABBCCDDEEFF;
        tx_ready_i = 1'b0;
        push(wbp);
        tick();
        k = 0;
        c = 0;
        guard = 0;
        while (k < NB && guard < 200) begin
            chk($sformatf("bp c%0d valid", c), tx_valid_o, 1'b1);
            chk($sformatf("bp c%0d data", c), tx_data_o, exp_byte(wbp, k));
            chk($sformatf("bp c%0d last", c), tx_last_o, (k == NB-1));
            tx_ready_i = ((c % 4) == 0) || ((c % 4) == 3);
            tick();
            if (tx_ready_i) k++;
            c++;
            guard++;
        end
        chk("bp bytes delivered", k, NB);
        chk("bp no extra byte", tx_valid_o, 1'b0);
        tx_ready_i = 1'b0;
        tick();

        // Overflow: six back-to-back words with the sink stalled.
        for (int j = 0; j < 6; j++) push(mk_word(j));
        chk("ovf level", fifo_level_o, 4);
        chk("ovf drop", drop_cnt_o, 1);
        chk("ovf head byte", tx_data_o, exp_byte(mk_word(0), 0));
        rx_frame(mk_word(0), "ovf f0", s0, l0);
        // Push while full during the IDLE pop: level unchanged, no drop.
        w6 = mk_word(6);
        tx_ready_i = 1'b0;
        push(w6);
        chk("full push+pop level", fifo_level_o, 4);
        chk("full push+pop drop", drop_cnt_o, 1);
        for (int j = 1; j < 5; j++) rx_frame(mk_word(j), $sformatf("ovf f%0d", j), s0, l0);
        rx_frame(w6, "ovf f6", s0, l0);
        chk("ovf drained level", fifo_level_o, 0);

        // Back-to-back: three queued words, exactly one bubble between frames.
        tx_ready_i = 1'b0;
        push(mk_word(7));
        push(mk_word(8));
        push(mk_word(9));
        chk("b2b level", fifo_level_o, 2);
        rx_frame(mk_word(7), "b2b f0", s0, l0);
        rx_frame(mk_word(8), "b2b f1", s1, l1);
        chk("b2b gap 0-1", s1 - l0, 2);
        chk("b2b bubble only 1 cyc", s1 - s0, NB + 1);
        rx_frame(mk_word(9), "b2b f2", s2, l2);
        chk("b2b gap 1-2", s2 - l1, 2);
        chk("b2b busy falls", busy_o, 1'b0);
        chk("b2b busy fall cycle", cyc - l2, 1);

        // Reset mid-frame after byte 5 has been accepted.
        tx_ready_i = 1'b1;
        push(mk_word(10));
        tick();
        for (int i = 0; i < 6; i++) tick();
        chk("mid byte6 shown", tx_data_o, exp_byte(mk_word(10), 6));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid rst valid", tx_valid_o, 1'b0);
        chk("mid rst data", tx_data_o, 8'h00);
        chk("mid rst last", tx_last_o, 1'b0);
        chk("mid rst level", fifo_level_o, 0);
        chk("mid rst drop", drop_cnt_o, 0);
        chk("mid rst busy", busy_o, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post rst idle", tx_valid_o, 1'b0);
        push(mk_word(11));
        rx_frame(mk_word(11), "post rst", s0, l0);
        chk("post rst idle end", busy_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
